// File: rtl/counter_2bit_arbiter.sv
// Round-robin arbiter/sequencer sharing one 2-bit up/down counter between two
// requesters; each transaction enables the counter for exactly the requested steps.
module counter_2bit_arbiter #(
    parameter int unsigned STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              dir0,
    input  logic [STEP_W-1:0] steps0,
    input  logic              req1,
    input  logic              dir1,
    input  logic [STEP_W-1:0] steps1,
    input  logic [1:0]        cnt_q,
    output logic              cnt_en,
    output logic              cnt_x,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [1:0]        result,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic              winner;
    logic              dir_q;
    logic [STEP_W-1:0] remaining;
    logic              last_served;
    logic [1:0]        result_q;

    logic              pick;
    logic              pick_dir;
    logic [STEP_W-1:0] pick_steps;

    // Under contention the requester not served last wins.
    always_comb begin
        pick       = req1 & (~req0 | ~last_served);
        pick_dir   = pick ? dir1 : dir0;
        pick_steps = pick ? steps1 : steps0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            winner      <= 1'b0;
            dir_q       <= 1'b0;
            remaining   <= '0;
            last_served <= 1'b1;
            result_q    <= '0;
            cnt_en      <= 1'b0;
            cnt_x       <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        winner    <= pick;
                        dir_q     <= pick_dir;
                        remaining <= pick_steps;
                        gnt0      <= ~pick;
                        gnt1      <= pick;
                        busy      <= 1'b1;
                        if (pick_steps != '0) begin
                            state  <= RUN;
                            cnt_en <= 1'b1;
                            cnt_x  <= pick_dir;
                        end else begin
                            state <= DONE;
                            done0 <= ~pick;
                            done1 <= pick;
                        end
                    end
                end
                RUN: begin
                    remaining <= remaining - STEP_W'(1);
                    if (remaining == STEP_W'(1)) begin
                        state  <= DONE;
                        cnt_en <= 1'b0;
                        cnt_x  <= 1'b0;
                        done0  <= ~winner;
                        done1  <= winner;
                    end
                end
                DONE: begin
                    result_q    <= cnt_q;
                    last_served <= winner;
                    state       <= IDLE;
                    gnt0        <= 1'b0;
                    gnt1        <= 1'b0;
                    done0       <= 1'b0;
                    done1       <= 1'b0;
                    busy        <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    cnt_en <= 1'b0;
                    cnt_x  <= 1'b0;
                    gnt0   <= 1'b0;
                    gnt1   <= 1'b0;
                    done0  <= 1'b0;
                    done1  <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    // The final count is visible in the DONE cycle itself, before it is registered.
    always_comb begin
        result = (state == DONE) ? cnt_q : result_q;
    end

    unused_dir_q_guard : assert property (@(posedge clk) disable iff (reset)
        !(cnt_en && (cnt_x != dir_q)));

endmodule

// File: tb/tb_counter_2bit_arbiter.sv
// Directed bench for counter_2bit_arbiter with a behavioural 2-bit wrap counter
// closing the loop on cnt_en/cnt_x -> cnt_q.
module tb_counter_2bit_arbiter;

    localparam int unsigned STEP_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req0 = 1'b0, dir0 = 1'b0, req1 = 1'b0, dir1 = 1'b0;
    logic [STEP_W-1:0] steps0 = '0, steps1 = '0;
    logic [1:0]        cnt_q;
    logic              cnt_en, cnt_x, gnt0, gnt1, done0, done1, busy;
    logic [1:0]        result;

    logic              load = 1'b0;
    logic [1:0]        load_val = 2'd0;
    logic [1:0]        cnt = 2'd0;

    int checks = 0;
    int errors = 0;
    int seq[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load)
            cnt <= load_val;
        else if (cnt_en)
            cnt <= cnt_x ? cnt + 2'd1 : cnt - 2'd1;
    end
    assign cnt_q = cnt;

    counter_2bit_arbiter #(.STEP_W(STEP_W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .dir0(dir0), .steps0(steps0),
        .req1(req1), .dir1(dir1), .steps1(steps1),
        .cnt_q(cnt_q), .cnt_en(cnt_en), .cnt_x(cnt_x),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .busy(busy)
    );

    task automatic set_cnt(input logic [1:0] v);
        load_val = v;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Samples 1 time unit after each edge until a done pulse; drops the finishing req.
    task automatic observe(input int max_cyc, input logic exp_dir,
                           output int n_en, output int n_g0, output int n_g1,
                           output int n_d0, output int n_d1, output int n_both,
                           output int n_bad, output logic [1:0] res, output bit timeout);
        bit prev_en;
        n_en = 0; n_g0 = 0; n_g1 = 0; n_d0 = 0; n_d1 = 0; n_both = 0; n_bad = 0;
        res = 2'bxx; timeout = 1'b1; prev_en = 1'b0;
        seq.delete();
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            if (prev_en) seq.push_back(int'(cnt_q));
            prev_en = cnt_en;
            if (cnt_en) n_en++;
            if (gnt0) n_g0++;
            if (gnt1) n_g1++;
            if (done0) n_d0++;
            if (done1) n_d1++;
            if ((gnt0 && done0) || (gnt1 && done1)) n_both++;
            if ((gnt0 && gnt1) || (done0 && done1)) n_bad++;
            if (cnt_en && cnt_x !== exp_dir) n_bad++;
            if (!cnt_en && cnt_x !== 1'b0) n_bad++;
            if (done0 || done1) begin
                res = result;
                if (done0) req0 = 1'b0;
                if (done1) req1 = 1'b0;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #7;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({cnt_en, cnt_x, gnt0, gnt1, done0, done1, busy} !== 7'b0 || result !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b x=%b g=%b%b d=%b%b busy=%b res=%0d, want all 0",
                     cnt_en, cnt_x, gnt0, gnt1, done0, done1, busy, result);
        end
    endtask

    task automatic test_up3();
        int n_en, n_g0, n_g1, n_d0, n_d1, n_both, n_bad;
        logic [1:0] res;
        bit to;
        set_cnt(2'd0);
        req0 = 1'b1; dir0 = 1'b1; steps0 = 4'd3;
        observe(20, 1'b1, n_en, n_g0, n_g1, n_d0, n_d1, n_both, n_bad, res, to);
        checks++;
        if (to || n_en != 3 || n_g0 != 4 || n_g1 != 0 || n_d0 != 1 || n_bad != 0) begin
            errors++;
            $display("FAIL up3_timing: to=%0d en=%0d g0=%0d g1=%0d d0=%0d bad=%0d, want 0/3/4/0/1/0",
                     to, n_en, n_g0, n_g1, n_d0, n_bad);
        end
        checks++;
        if (res !== 2'd3) begin
            errors++;
            $display("FAIL up3_result_done: got %0d want 3", res);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || result !== 2'd3 || gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL up3_after: busy=%b result=%0d gnt0=%b, want 0/3/0", busy, result, gnt0);
        end
    endtask

    task automatic test_down5();
        int n_en, n_g0, n_g1, n_d0, n_d1, n_both, n_bad;
        logic [1:0] res;
        bit to;
        int exp_seq[5] = '{2, 1, 0, 3, 2};
        bit seq_ok;
        req1 = 1'b1; dir1 = 1'b0; steps1 = 4'd5;
        observe(20, 1'b0, n_en, n_g0, n_g1, n_d0, n_d1, n_both, n_bad, res, to);
        checks++;
        if (to || n_en != 5 || n_g1 != 6 || n_g0 != 0 || n_d1 != 1 || n_d0 != 0 || n_bad != 0) begin
            errors++;
            $display("FAIL down5_timing: to=%0d en=%0d g0=%0d g1=%0d d0=%0d d1=%0d bad=%0d",
                     to, n_en, n_g0, n_g1, n_d0, n_d1, n_bad);
        end
        seq_ok = (seq.size() == 5);
        if (seq_ok)
            for (int i = 0; i < 5; i++) if (seq[i] != exp_seq[i]) seq_ok = 1'b0;
        checks++;
        if (!seq_ok) begin
            errors++;
            $display("FAIL down5_sequence: got %p want 2,1,0,3,2", seq);
        end
        checks++;
        if (res !== 2'd2) begin
            errors++;
            $display("FAIL down5_result: got %0d want 2", res);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int order[$];
        int idle_cnt, overlap;
        bit g0_prev, g1_prev;
        apply_reset();
        req0 = 1'b1; dir0 = 1'b1; steps0 = 4'd2;
        req1 = 1'b1; dir1 = 1'b1; steps1 = 4'd2;
        idle_cnt = 0; overlap = 0; g0_prev = 1'b0; g1_prev = 1'b0;
        // 3 transactions of RUN,RUN,DONE plus one IDLE each: 11 samples up to the third DONE
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            if (gnt0 && !g0_prev) order.push_back(0);
            if (gnt1 && !g1_prev) order.push_back(1);
            if ((gnt0 && gnt1) || (done0 && done1)) overlap++;
            if (!busy) idle_cnt++;
            g0_prev = gnt0; g1_prev = gnt1;
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 0) begin
            errors++;
            $display("FAIL b2b_order: got %p want 0,1,0", order);
        end
        checks++;
        if (idle_cnt != 2) begin
            errors++;
            $display("FAIL b2b_idle_gap: got %0d idle cycles want 2", idle_cnt);
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL b2b_overlap: got %0d overlapping cycles want 0", overlap);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_steps();
        int n_en, n_g0, n_g1, n_d0, n_d1, n_both, n_bad;
        logic [1:0] res;
        bit to;
        set_cnt(2'd1);
        req0 = 1'b1; dir0 = 1'b1; steps0 = 4'd0;
        observe(10, 1'b1, n_en, n_g0, n_g1, n_d0, n_d1, n_both, n_bad, res, to);
        checks++;
        if (to || n_en != 0 || n_g0 != 1 || n_d0 != 1 || n_both != 1) begin
            errors++;
            $display("FAIL zero_steps_timing: to=%0d en=%0d g0=%0d d0=%0d same=%0d, want 0/0/1/1/1",
                     to, n_en, n_g0, n_d0, n_both);
        end
        checks++;
        if (res !== 2'd1) begin
            errors++;
            $display("FAIL zero_steps_result: got %0d want 1", res);
        end
        @(posedge clk); #1;
        checks++;
        if (result !== 2'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_steps_after: result=%0d busy=%b want 1/0", result, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int n_en, n_g0, n_g1, n_d0, n_d1, n_both, n_bad;
        logic [1:0] res;
        bit to;
        set_cnt(2'd0);
        req0 = 1'b1; dir0 = 1'b1; steps0 = 4'd6;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (cnt_q !== 2'd2 || cnt_en !== 1'b1) begin
            errors++;
            $display("FAIL midrun_pre: cnt_q=%0d cnt_en=%b want 2/1", cnt_q, cnt_en);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (cnt_en !== 1'b0 || gnt0 !== 1'b0 || busy !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL midrun_async_drop: en=%b gnt0=%b busy=%b done0=%b want 0",
                     cnt_en, gnt0, busy, done0);
        end
        #1 reset = 1'b0;
        // counter itself was not reset: restart from 2, +6 -> 0
        observe(20, 1'b1, n_en, n_g0, n_g1, n_d0, n_d1, n_both, n_bad, res, to);
        checks++;
        if (to || n_en != 6 || n_g0 != 7 || n_d0 != 1 || n_g1 != 0 || n_bad != 0) begin
            errors++;
            $display("FAIL midrun_regrant: to=%0d en=%0d g0=%0d d0=%0d g1=%0d bad=%0d",
                     to, n_en, n_g0, n_d0, n_g1, n_bad);
        end
        checks++;
        if (res !== 2'd0) begin
            errors++;
            $display("FAIL midrun_result: got %0d want 0", res);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_max_steps();
        int n_en, n_g0, n_g1, n_d0, n_d1, n_both, n_bad;
        logic [1:0] res;
        bit to;
        set_cnt(2'd0);
        req1 = 1'b1; dir1 = 1'b1; steps1 = 4'd15;
        observe(30, 1'b1, n_en, n_g0, n_g1, n_d0, n_d1, n_both, n_bad, res, to);
        checks++;
        if (to || n_en != 15 || n_g1 != 16 || n_d1 != 1 || n_bad != 0) begin
            errors++;
            $display("FAIL max_steps_timing: to=%0d en=%0d g1=%0d d1=%0d bad=%0d want 0/15/16/1/0",
                     to, n_en, n_g1, n_d1, n_bad);
        end
        checks++;
        if (seq.size() != 15 || seq[3] != 0 || seq[14] != 3) begin
            errors++;
            $display("FAIL max_steps_wrap: size=%0d seq=%p want 15 entries, [3]=0 [14]=3",
                     seq.size(), seq);
        end
        checks++;
        if (res !== 2'd3) begin
            errors++;
            $display("FAIL max_steps_result: got %0d want 3", res);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_up3();
        test_down5();
        test_back_to_back();
        test_zero_steps();
        test_reset_mid_run();
        test_max_steps();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
